// File: rtl/movegen_pkg.sv
// Shared constants for the tt_um_chess move-generator driver:
// command opcodes, host ops, result fields and FSM state codes.
package movegen_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_FRIEND = 4'h8;
  localparam logic [3:0] OP_FLIP   = 4'h9;
  localparam logic [3:0] OP_ROT    = 4'hA;
  localparam logic [3:0] OP_LOAD   = 4'hB;
  localparam logic [3:0] OP_ENALL  = 4'hC;
  localparam logic [3:0] OP_SETEN  = 4'hD;
  localparam logic [3:0] OP_FV     = 4'hE;
  localparam logic [3:0] OP_FA     = 4'hF;

  typedef enum logic [1:0] {
    HOST_LOAD   = 2'd0,
    HOST_ROTATE = 2'd1,
    HOST_FLIP   = 2'd2,
    HOST_GEN    = 2'd3
  } host_op_e;

  localparam int RES_ILLEGAL = 7;
  localparam int RES_NONE    = 6;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_CMD      = 4'd1;
  localparam logic [3:0] S_EN_ALL   = 4'd2;
  localparam logic [3:0] S_FV_ISSUE = 4'd3;
  localparam logic [3:0] S_FV_WAIT  = 4'd4;
  localparam logic [3:0] S_FA_ISSUE = 4'd5;
  localparam logic [3:0] S_FA_WAIT  = 4'd6;
  localparam logic [3:0] S_EMIT     = 4'd7;
  localparam logic [3:0] S_MASK_A   = 4'd8;
  localparam logic [3:0] S_REFRIEND = 4'd9;
  localparam logic [3:0] S_MASK_V   = 4'd10;
  localparam logic [3:0] S_DONE     = 4'd11;

endpackage

// File: rtl/movegen_if.sv
// Host request and move-stream handshakes of the driver.
// master = host controller side, slave = movegen_driver.
interface movegen_if;
  import movegen_pkg::*;

  logic       host_valid;
  logic       host_ready;
  logic [1:0] host_op;
  logic [5:0] host_square;
  logic [3:0] host_piece;
  logic       mv_valid;
  logic       mv_ready;
  logic [5:0] mv_from;
  logic [5:0] mv_to;

  modport master (
    output host_valid, host_op,
    output host_square, host_piece,
    output mv_ready,
    input  host_ready,
    input  mv_valid, mv_from, mv_to
  );

  modport slave (
    input  host_valid, host_op,
    input  host_square, host_piece,
    input  mv_ready,
    output host_ready,
    output mv_valid, mv_from, mv_to
  );

endinterface

// File: rtl/mg_cmd_encode.sv
// Maps (opcode, square, piece) onto the chip's addr/data lanes.
// OP_NOP yields the 0x00/0x00 idle pattern.
module mg_cmd_encode
  import movegen_pkg::*;
(
  input  logic [3:0] op,
  input  logic [5:0] sq,
  input  logic [3:0] pc,
  output logic [7:0] addr,
  output logic [7:0] data
);

  always_comb begin
    addr = {op, 4'h0};
    data = 8'h00;
    unique case (1'b1)
      (op == OP_LOAD): begin
        addr = {op, 2'b00, sq[5:4]};
        data = {sq[3:0], pc};
      end
      (op == OP_SETEN),
      (op == OP_FA): begin
        addr = {op, 2'b00, sq[5:4]};
        data = {sq[3:0], 4'h0};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/movegen_driver.sv
// Host-side initiator for the tt_um_chess move generator:
// board setup commands and the MVV-LVA GENERATE sequence.
module movegen_driver
  import movegen_pkg::*;
#(
  parameter int RESP_LAT = 9,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  movegen_if.slave         bus,
  output logic             gen_done,
  output logic             gen_illegal,
  output logic [CNT_W-1:0] move_count,
  output logic [7:0]       mg_addr,
  output logic [7:0]       mg_data,
  input  logic [7:0]       mg_result
);

  localparam int CW = (RESP_LAT < 1) ? 1
                    : $clog2(RESP_LAT + 1);

  logic [3:0]    state, state_d;
  logic [CW-1:0] cnt;
  logic [5:0]    victim, aggr;
  logic          illegal_q;

  logic [3:0] op_d;
  logic [5:0] sq_d;
  logic [3:0] pc_d;
  logic [7:0] addr_d, data_d;

  logic       resp_now;
  logic       res_ill, res_none;
  logic       gen_req, mv_hs;
  logic [5:0] res_sq;

  assign resp_now = (cnt == '0);
  assign res_ill  = mg_result[RES_ILLEGAL];
  assign res_none = mg_result[RES_NONE];
  assign res_sq   = mg_result[5:0];

  assign gen_req = (state == S_IDLE) && bus.host_valid
                && (bus.host_op == HOST_GEN);
  assign mv_hs   = (state == S_EMIT) && bus.mv_ready;

  assign bus.host_ready = (state == S_IDLE);
  assign bus.mv_valid   = (state == S_EMIT);
  assign bus.mv_from    = aggr;
  assign bus.mv_to      = victim;

  assign gen_done    = (state == S_DONE);
  assign gen_illegal = gen_done && illegal_q;

  // The opcode chosen on a transition is the command of the
  // state being entered; it appears registered on the lanes.
  always_comb begin
    state_d = state;
    op_d    = OP_NOP;
    sq_d    = victim;
    pc_d    = 4'h0;
    case (state)
      S_IDLE: begin
        if (bus.host_valid) begin
          state_d = S_CMD;
          case (bus.host_op)
            HOST_LOAD: begin
              op_d = OP_LOAD;
              sq_d = bus.host_square;
              pc_d = bus.host_piece;
            end
            HOST_ROTATE: op_d = OP_ROT;
            HOST_FLIP:   op_d = OP_FLIP;
            default: begin
              state_d = S_EN_ALL;
              op_d    = OP_ENALL;
            end
          endcase
        end
      end
      S_CMD: state_d = S_IDLE;
      S_EN_ALL: begin
        state_d = S_FV_ISSUE;
        op_d    = OP_FV;
      end
      S_FV_ISSUE: state_d = S_FV_WAIT;
      S_FV_WAIT: begin
        if (resp_now) begin
          if (res_ill || res_none) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FA_ISSUE;
            op_d    = OP_FA;
            sq_d    = res_sq;
          end
        end
      end
      S_FA_ISSUE: state_d = S_FA_WAIT;
      S_FA_WAIT: begin
        if (resp_now) begin
          if (res_none) begin
            state_d = S_REFRIEND;
            op_d    = OP_FRIEND;
          end else begin
            state_d = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (bus.mv_ready) begin
          state_d = S_MASK_A;
          op_d    = OP_SETEN;
          sq_d    = aggr;
        end
      end
      S_MASK_A: begin
        state_d = S_FA_ISSUE;
        op_d    = OP_FA;
      end
      S_REFRIEND: begin
        state_d = S_MASK_V;
        op_d    = OP_SETEN;
      end
      S_MASK_V: begin
        state_d = S_FV_ISSUE;
        op_d    = OP_FV;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  mg_cmd_encode u_enc (
    .op   (op_d),
    .sq   (sq_d),
    .pc   (pc_d),
    .addr (addr_d),
    .data (data_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      victim     <= '0;
      aggr       <= '0;
      illegal_q  <= 1'b0;
      move_count <= '0;
      mg_addr    <= 8'h00;
      mg_data    <= 8'h00;
    end else begin
      state   <= state_d;
      mg_addr <= addr_d;
      mg_data <= data_d;
      if (state == S_FV_ISSUE || state == S_FA_ISSUE)
        cnt <= CW'(RESP_LAT - 1);
      else if (cnt != '0)
        cnt <= cnt - CW'(1);
      if (gen_req) begin
        move_count <= '0;
        illegal_q  <= 1'b0;
      end
      if (state == S_FV_WAIT && resp_now) begin
        illegal_q <= res_ill;
        if (!res_ill && !res_none)
          victim <= res_sq;
      end
      if (state == S_FA_WAIT && resp_now && !res_none)
        aggr <= res_sq;
      if (mv_hs && move_count != '1)
        move_count <= move_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_movegen_driver.sv
// Directed bench for movegen_driver with a scripted
// fixed-latency responder standing in for the chip.
module tb_movegen_driver;
  import movegen_pkg::*;

  localparam int LAT = 9;
  localparam int CW  = 8;

  typedef struct {
    logic [1:0] op;
    logic [5:0] sq;
    logic [3:0] pc;
    logic [7:0] ea;
    logic [7:0] ed;
  } vec_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } cmd_t;

  typedef struct {
    logic [5:0] f;
    logic [5:0] t;
  } mv_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          gen_done, gen_illegal;
  logic [CW-1:0] move_count;
  logic [7:0]    mg_addr, mg_data;
  logic [7:0]    mg_result = 8'h55;

  movegen_if hif ();

  movegen_driver #(
    .RESP_LAT (LAT),
    .CNT_W    (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (hif),
    .gen_done    (gen_done),
    .gen_illegal (gen_illegal),
    .move_count  (move_count),
    .mg_addr     (mg_addr),
    .mg_data     (mg_data),
    .mg_result   (mg_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scripted chip: answers each FIND exactly LAT cycles later
  logic [7:0] script[$];
  int script_id = 0;
  int seen_id   = 0;
  int ptr       = 0;
  int resp_cyc  = -100;
  logic [7:0] resp_val = 8'h00;
  int last_find = -1000;
  int gap_bad   = 0;

  always @(negedge clk) begin
    if (script_id != seen_id) begin
      seen_id  = script_id;
      ptr      = 0;
      resp_cyc = -100;
    end
    mg_result = (cyc == resp_cyc) ? resp_val : 8'h55;
    if (mg_addr[7:5] == 3'b111) begin
      if (cyc - last_find < LAT + 1) gap_bad++;
      last_find = cyc;
      resp_val = (ptr < script.size()) ? script[ptr]
                                       : 8'h40;
      ptr++;
      resp_cyc = cyc + LAT;
    end
  end

  cmd_t cmd_q[$];
  mv_t  mv_q[$];
  int   done_cnt = 0;
  logic last_ill = 1'b0;
  int   last_cnt = 0;

  always @(negedge clk) begin
    #1;
    if (mg_addr != 8'h00 || mg_data != 8'h00)
      cmd_q.push_back('{mg_addr, mg_data});
    if (hif.mv_valid && hif.mv_ready)
      mv_q.push_back('{hif.mv_from, hif.mv_to});
    if (gen_done) begin
      done_cnt++;
      last_ill = gen_illegal;
      last_cnt = int'(move_count);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] op,
                      input logic [5:0] sq,
                      input logic [3:0] pc);
    int n = 0;
    @(negedge clk);
    while (!hif.host_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!hif.host_ready) chk("send_ready", 0, 1);
    hif.host_valid  = 1'b1;
    hif.host_op     = op;
    hif.host_square = sq;
    hif.host_piece  = pc;
    @(negedge clk);
    hif.host_valid = 1'b0;
  endtask

  task automatic wait_done(input int m, input int bound);
    int n = 0;
    while (done_cnt == m && n < bound) begin
      @(negedge clk);
      #2;
      n++;
    end
    repeat (3) @(negedge clk);
    #2;
    chk("gen_done_pulses", done_cnt - m, 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
  endtask

  task automatic has_move(input string nm,
                          input int from_i,
                          input logic [5:0] f,
                          input logic [5:0] t);
    int hit = 0;
    for (int i = from_i; i < mv_q.size(); i++)
      if (mv_q[i].f == f && mv_q[i].t == t) hit++;
    chk(nm, hit, 1);
  endtask

  vec_t vt[5];
  cmd_t exp3[8];
  int   cm, mm, dm;
  cmd_t c;

  initial begin
    vt[0] = '{2'd0, 6'h2A, 4'hB, 8'hB2, 8'hAB};
    vt[1] = '{2'd0, 6'h3F, 4'h7, 8'hB3, 8'hF7};
    vt[2] = '{2'd0, 6'h05, 4'h9, 8'hB0, 8'h59};
    vt[3] = '{2'd1, 6'h11, 4'h3, 8'hA0, 8'h00};
    vt[4] = '{2'd2, 6'h22, 4'h4, 8'h90, 8'h00};

    exp3[0] = '{8'hC0, 8'h00};
    exp3[1] = '{8'hE0, 8'h00};
    exp3[2] = '{8'hF2, 8'h40};
    exp3[3] = '{8'hD1, 8'hC0};
    exp3[4] = '{8'hF2, 8'h40};
    exp3[5] = '{8'h80, 8'h00};
    exp3[6] = '{8'hD2, 8'h40};
    exp3[7] = '{8'hE0, 8'h00};

    hif.host_valid  = 1'b0;
    hif.host_op     = 2'd0;
    hif.host_square = 6'd0;
    hif.host_piece  = 4'd0;
    hif.mv_ready    = 1'b1;

    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rst_host_ready", hif.host_ready, 1);
    chk("rst_mv_valid", hif.mv_valid, 0);
    chk("rst_gen_done", gen_done, 0);
    chk("rst_gen_illegal", gen_illegal, 0);
    chk("rst_mg_addr", mg_addr, 8'h00);
    chk("rst_mg_data", mg_data, 8'h00);
    chk("rst_move_count", move_count, 0);

    for (int i = 0; i < 5; i++) begin
      cm = cmd_q.size();
      send(vt[i].op, vt[i].sq, vt[i].pc);
      #2;
      chk($sformatf("v%0d_addr", i), mg_addr, vt[i].ea);
      chk($sformatf("v%0d_data", i), mg_data, vt[i].ed);
      chk($sformatf("v%0d_busy", i), hif.host_ready, 0);
      @(negedge clk);
      #2;
      chk($sformatf("v%0d_ready", i), hif.host_ready, 1);
      chk($sformatf("v%0d_noop", i), mg_addr, 8'h00);
      chk($sformatf("v%0d_ncmd", i), cmd_q.size() - cm, 1);
    end

    script = '{8'h24, 8'h1C, 8'h40, 8'h40};
    script_id++;
    cm = cmd_q.size();
    mm = mv_q.size();
    dm = done_cnt;
    send(2'd3, 6'd0, 4'd0);
    wait_done(dm, 400);
    chk("gen_ill", last_ill, 0);
    chk("gen_count", last_cnt, 1);
    chk("gen_ncmd", cmd_q.size() - cm, 8);
    for (int i = 0; i < 8 && cm + i < cmd_q.size(); i++) begin
      chk($sformatf("gen_cmd%0d_a", i), cmd_q[cm + i].a, exp3[i].a);
      chk($sformatf("gen_cmd%0d_d", i), cmd_q[cm + i].d, exp3[i].d);
    end
    chk("gen_nmoves", mv_q.size() - mm, 1);
    has_move("gen_move", mm, 6'h1C, 6'h24);
    chk("gen_gap", gap_bad, 0);

    script = '{8'h24, 8'h1C, 8'h40, 8'h40};
    script_id++;
    dm = done_cnt;
    hif.mv_ready = 1'b0;
    send(2'd3, 6'd0, 4'd0);
    for (int n = 0; n < 300 && !hif.mv_valid; n++) begin
      @(negedge clk);
      #2;
    end
    chk("stall_reached", hif.mv_valid, 1);
    chk("stall_count0", move_count, 0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_valid", k), hif.mv_valid, 1);
      chk($sformatf("stall%0d_from", k), hif.mv_from, 6'h1C);
      chk($sformatf("stall%0d_to", k), hif.mv_to, 6'h24);
      chk($sformatf("stall%0d_addr", k), mg_addr, 8'h00);
      @(negedge clk);
      #2;
    end
    hif.mv_ready = 1'b1;
    wait_done(dm, 400);
    chk("stall_count", last_cnt, 1);

    script = '{8'h84};
    script_id++;
    cm = cmd_q.size();
    mm = mv_q.size();
    dm = done_cnt;
    send(2'd3, 6'd0, 4'd0);
    wait_done(dm, 200);
    chk("ill_flag", last_ill, 1);
    chk("ill_count", last_cnt, 0);
    chk("ill_nmoves", mv_q.size() - mm, 0);
    chk("ill_ncmd", cmd_q.size() - cm, 2);
    if (cmd_q.size() - cm >= 2) begin
      chk("ill_cmd0", cmd_q[cm].a, 8'hC0);
      chk("ill_cmd1", cmd_q[cm + 1].a, 8'hE0);
    end

    pulse_reset();
    cm = cmd_q.size();
    send(2'd0, 6'd12, 4'h0);
    #2;
    chk("pawn_load_a", mg_addr, 8'hB0);
    chk("pawn_load_d", mg_data, 8'hC0);
    script = '{8'h14, 8'h0C, 8'h40, 8'h1C,
               8'h0C, 8'h40, 8'h40};
    script_id++;
    mm = mv_q.size();
    dm = done_cnt;
    send(2'd3, 6'd0, 4'd0);
    wait_done(dm, 600);
    chk("pawn_nmoves", mv_q.size() - mm, 2);
    has_move("pawn_m20", mm, 6'd12, 6'd20);
    has_move("pawn_m28", mm, 6'd12, 6'd28);
    chk("pawn_count", last_cnt, 2);

    script = '{8'h14, 8'h0C, 8'h40, 8'h1C,
               8'h0C, 8'h40, 8'h40};
    script_id++;
    cm = cmd_q.size();
    mm = mv_q.size();
    dm = done_cnt;
    send(2'd3, 6'd0, 4'd0);
    c = '{8'h00, 8'h00};
    for (int n = 0; n < 100 && c.a[7:4] != 4'hF; n++) begin
      @(negedge clk);
      #2;
      if (cmd_q.size() > cm) c = cmd_q[cmd_q.size() - 1];
    end
    chk("abort_fa_seen", c.a, 8'hF1);
    repeat (3) @(negedge clk);
    pulse_reset();
    chk("abort_ready", hif.host_ready, 1);
    chk("abort_mv_valid", hif.mv_valid, 0);
    chk("abort_addr", mg_addr, 8'h00);
    repeat (30) @(negedge clk);
    #2;
    chk("abort_no_done", done_cnt - dm, 0);
    chk("abort_no_move", mv_q.size() - mm, 0);

    script = '{8'h14, 8'h0C, 8'h40, 8'h1C,
               8'h0C, 8'h40, 8'h40};
    script_id++;
    mm = mv_q.size();
    dm = done_cnt;
    send(2'd3, 6'd0, 4'd0);
    wait_done(dm, 600);
    chk("regen_nmoves", mv_q.size() - mm, 2);
    has_move("regen_m20", mm, 6'd12, 6'd20);
    has_move("regen_m28", mm, 6'd12, 6'd28);

    script = {};
    script.push_back(8'h24);
    for (int i = 0; i < 260; i++) script.push_back(8'h1C);
    script.push_back(8'h40);
    script.push_back(8'h40);
    script_id++;
    mm = mv_q.size();
    dm = done_cnt;
    send(2'd3, 6'd0, 4'd0);
    wait_done(dm, 6000);
    chk("sat_nmoves", mv_q.size() - mm, 260);
    chk("sat_count", last_cnt, 255);
    chk("sat_port", move_count, 8'hFF);
    chk("final_gap", gap_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
